// File: rtl/dino_jump_physics_if.sv
// rtl/dino_jump_physics_if.sv - control/observation bundle for the dino vertical physics engine
interface dino_jump_physics_if #(
  parameter int POS_W = 6,
  parameter int VEL_W = 4
);
  logic [1:0]              game_tick;
  logic                    game_over;
  logic                    jump_pulse;
  logic                    jump_held;
  logic                    button_down;
  logic signed [POS_W-1:0] position;
  logic signed [VEL_W-1:0] velocity;
  logic                    airborne;
  logic [1:0]              state;
  logic                    landed;

  modport master (
    output game_tick, game_over, jump_pulse, jump_held, button_down,
    input  position, velocity, airborne, state, landed
  );

  modport slave (
    input  game_tick, game_over, jump_pulse, jump_held, button_down,
    output position, velocity, airborne, state, landed
  );
endinterface

// File: rtl/dino_jump_physics.sv
// rtl/dino_jump_physics.sv - dino vertical physics engine; optional jump buffer via JUMP_BUFFER_EN
module dino_jump_physics #(
  parameter int POS_W        = 6,
  parameter int VEL_W        = 4,
  parameter int JUMP_VEL     = -7,
  parameter int ACCEL        = 1,
  parameter int HOLD_ACCEL   = 0,
  parameter int MAX_HOLD     = 3,
  parameter int TERM_VEL     = 6,
  parameter int FASTDROP_VEL = 6,
  parameter int CEILING      = -30,
  parameter int JUMP_BUF     = 2
) (
  input logic               clk,
  input logic               rst,
  dino_jump_physics_if.slave bus
);

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2,
    DROP   = 2'd3
  } state_t;

  localparam int HC_W = $clog2(MAX_HOLD + 2);
  localparam logic [HC_W-1:0]        HOLD_MAX = HC_W'(MAX_HOLD);
  localparam logic signed [VEL_W:0]   G_HOLD   = (VEL_W+1)'(HOLD_ACCEL);
  localparam logic signed [VEL_W:0]   G_NORM   = (VEL_W+1)'(ACCEL);
  localparam logic signed [VEL_W:0]   V_TERM   = (VEL_W+1)'(TERM_VEL);
  localparam logic signed [VEL_W-1:0] V_JUMP   = VEL_W'(JUMP_VEL);
  localparam logic signed [VEL_W-1:0] V_FAST   = VEL_W'(FASTDROP_VEL);
  localparam logic signed [POS_W:0]   CEIL_EXT = (POS_W+1)'(CEILING);

  state_t                  state_q, state_d;
  logic signed [POS_W-1:0] pos_q, pos_d;
  logic signed [VEL_W-1:0] vel_q, vel_d;
  logic [HC_W-1:0]         hold_q, hold_d;
  logic                    landed_q, landed_d;
  logic                    airborne;
  logic                    jump_req;

`ifdef JUMP_BUFFER_EN
  localparam int BC_W = $clog2(JUMP_BUF + 2);
  logic            pend_q, pend_d;
  logic [BC_W-1:0] buf_q, buf_d;
`endif

  logic signed [VEL_W:0] grav;
  logic signed [VEL_W:0] vel_sum;
  logic signed [VEL_W:0] vel_new;
  logic signed [POS_W:0] pos_sum;

  // Extra-bit arithmetic so the saturation and clamp compares see the true result
  assign airborne = (state_q != GROUND);
  assign grav     = (state_q == RISE && bus.jump_held && hold_q < HOLD_MAX) ? G_HOLD : G_NORM;
  assign vel_sum  = $signed({vel_q[VEL_W-1], vel_q}) + grav;
  assign vel_new  = (vel_sum > V_TERM) ? V_TERM : vel_sum;
  assign pos_sum  = $signed({pos_q[POS_W-1], pos_q})
                  + $signed({{(POS_W+1-VEL_W){vel_q[VEL_W-1]}}, vel_q});

  // Next-state logic: velocity phase wins over position phase; game_over freezes everything
  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    vel_d    = vel_q;
    hold_d   = hold_q;
    landed_d = 1'b0;
`ifdef JUMP_BUFFER_EN
    pend_d   = pend_q;
    buf_d    = buf_q;
    jump_req = bus.jump_pulse | pend_q;
`else
    jump_req = bus.jump_pulse;
`endif
    if (!bus.game_over) begin
      if (bus.game_tick[0]) begin
        if (bus.button_down && !airborne) begin
          vel_d = '0;
        end else if (bus.button_down) begin
          vel_d   = V_FAST;
          state_d = DROP;
        end else if (jump_req && !airborne) begin
          vel_d   = V_JUMP;
          state_d = RISE;
          hold_d  = '0;
        end else if (state_q == RISE || state_q == FALL) begin
          vel_d = vel_new[VEL_W-1:0];
          if (state_q == RISE && hold_q < HOLD_MAX) hold_d = hold_q + 1'b1;
          if (!vel_new[VEL_W]) state_d = FALL;
        end
`ifdef JUMP_BUFFER_EN
        // On the ground the pending request is either consumed or cancelled
        if (!airborne) begin
          pend_d = 1'b0;
        end else if (bus.jump_pulse) begin
          pend_d = 1'b1;
          buf_d  = BC_W'(JUMP_BUF);
        end
`endif
      end else if (bus.game_tick[1] && airborne) begin
        if (pos_sum >= 0) begin
          pos_d    = '0;
          vel_d    = '0;
          state_d  = GROUND;
          landed_d = 1'b1;
        end else begin
          if (pos_sum < CEIL_EXT) begin
            pos_d   = CEIL_EXT[POS_W-1:0];
            vel_d   = '0;
            state_d = FALL;
          end else begin
            pos_d = pos_sum[POS_W-1:0];
          end
`ifdef JUMP_BUFFER_EN
          if (pend_q) begin
            if (buf_q <= 1) begin
              pend_d = 1'b0;
              buf_d  = '0;
            end else begin
              buf_d = buf_q - 1'b1;
            end
          end
`endif
        end
      end
    end
  end

  // State registers with synchronous reset taking priority over freeze
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= GROUND;
      pos_q    <= '0;
      vel_q    <= '0;
      hold_q   <= '0;
      landed_q <= 1'b0;
`ifdef JUMP_BUFFER_EN
      pend_q   <= 1'b0;
      buf_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      vel_q    <= vel_d;
      hold_q   <= hold_d;
      landed_q <= landed_d;
`ifdef JUMP_BUFFER_EN
      pend_q   <= pend_d;
      buf_q    <= buf_d;
`endif
    end
  end

  assign bus.position = pos_q;
  assign bus.velocity = vel_q;
  assign bus.airborne = airborne;
  assign bus.state    = state_q;
  assign bus.landed   = landed_q;

endmodule

// File: tb/tb_dino_jump_physics.sv
// tb/tb_dino_jump_physics.sv - self-checking bench for dino_jump_physics (JUMP_BUFFER_EN aware)
module tb_dino_jump_physics;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  dino_jump_physics_if #(.POS_W(6), .VEL_W(4)) bus ();

  dino_jump_physics dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: game rules on plain integers
  int m_pos, m_vel, m_st, m_hold, m_landed, m_pend, m_buf;

  always @(posedge clk) begin
    int  sum;
    int  g;
    bit  air;
    if (rst) begin
      m_pos = 0; m_vel = 0; m_st = 0; m_hold = 0; m_landed = 0; m_pend = 0; m_buf = 0;
    end else begin
      m_landed = 0;
      if (!bus.game_over) begin
        air = (m_st != 0);
        if (bus.game_tick[0]) begin
          if (bus.button_down && !air) begin
            m_vel = 0;
            m_pend = 0;
          end else if (bus.button_down) begin
            m_vel = 6;
            m_st = 3;
          end else if (!air && (bus.jump_pulse || m_pend != 0)) begin
            m_vel = -7; m_st = 1; m_hold = 0; m_pend = 0;
          end else if (m_st == 1 || m_st == 2) begin
            g = (m_st == 1 && bus.jump_held && m_hold < 3) ? 0 : 1;
            m_vel = (m_vel + g > 6) ? 6 : m_vel + g;
            if (m_st == 1 && m_hold < 3) m_hold++;
            if (m_vel >= 0) m_st = 2;
          end
`ifdef JUMP_BUFFER_EN
          if (air && bus.jump_pulse) begin
            m_pend = 1; m_buf = 2;
          end
`endif
        end else if (bus.game_tick[1] && air) begin
          sum = m_pos + m_vel;
          if (sum >= 0) begin
            m_pos = 0; m_vel = 0; m_st = 0; m_landed = 1;
          end else begin
            if (sum < -30) begin
              m_pos = -30; m_vel = 0; m_st = 2;
            end else begin
              m_pos = sum;
            end
            if (m_pend != 0) begin
              m_buf--;
              if (m_buf <= 0) begin m_pend = 0; m_buf = 0; end
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_position", int'($signed(bus.position)), m_pos);
      chk("cyc_velocity", int'($signed(bus.velocity)), m_vel);
      chk("cyc_state",    int'(bus.state), m_st);
      chk("cyc_airborne", int'(bus.airborne), (m_st != 0) ? 1 : 0);
      chk("cyc_landed",   int'(bus.landed), m_landed);
    end
  end

  function automatic int pos_now();
    return int'($signed(bus.position));
  endfunction

  function automatic int vel_now();
    return int'($signed(bus.velocity));
  endfunction

  task automatic cyc(input logic [1:0] t, input logic p, input logic h, input logic d);
    bus.game_tick   = t;
    bus.jump_pulse  = p;
    bus.jump_held   = h;
    bus.button_down = d;
    @(posedge clk);
    #2;
    bus.game_tick  = 2'b00;
    bus.jump_pulse = 1'b0;
  endtask

  task automatic vel_tick(input logic p, input logic h, input logic d);
    cyc(2'b01, p, h, d);
  endtask

  task automatic pos_tick(input logic h);
    cyc(2'b10, 1'b0, h, 1'b0);
  endtask

  // One position phase, then (n-1) velocity/position pairs
  task automatic advance(input int n);
    pos_tick(1'b0);
    for (int i = 1; i < n; i++) begin
      vel_tick(1'b0, 1'b0, 1'b0);
      pos_tick(1'b0);
    end
  endtask

  task automatic jump_to(input int n);
    vel_tick(1'b1, 1'b0, 1'b0);
    advance(n);
  endtask

  task automatic run_to_ground();
    for (int n = 0; n < 60 && m_st != 0; n++) begin
      vel_tick(1'b0, 1'b0, 1'b0);
      pos_tick(1'b0);
    end
    chk("ground_reached", int'(bus.state), 0);
    cyc(2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  int exp1 [16] = '{-7, -13, -18, -22, -25, -27, -28, -28, -27, -25, -22, -18, -13, -7, -1, 0};
  int exp2 [5]  = '{-7, -14, -21, -28, -30};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.game_tick   = 2'b00;
    bus.game_over   = 1'b0;
    bus.jump_pulse  = 1'b0;
    bus.jump_held   = 1'b0;
    bus.button_down = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #2;
    cmp_en = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    chk("reset_pos", pos_now(), 0);
    chk("reset_state", int'(bus.state), 0);
    chk("reset_landed", int'(bus.landed), 0);

    // Plain jump, no hold
    vel_tick(1'b1, 1'b0, 1'b0);
    chk("t1_rise", int'(bus.state), 1);
    for (int i = 0; i < 16; i++) begin
      pos_tick(1'b0);
      chk("t1_pos", pos_now(), exp1[i]);
      if (i == 6) chk("t1_still_rise", int'(bus.state), 1);
      if (i == 7) chk("t1_fall", int'(bus.state), 2);
`ifndef JUMP_BUFFER_EN
      if (i < 15) vel_tick(i == 3 || i == 10, 1'b0, 1'b0);
`else
      if (i < 15) vel_tick(1'b0, 1'b0, 1'b0);
`endif
    end
    chk("t1_landed", int'(bus.landed), 1);
    chk("t1_ground", int'(bus.state), 0);
    cyc(2'b00, 1'b0, 1'b0, 1'b0);
    chk("t1_landed_pulse", int'(bus.landed), 0);

    // Held jump hits the ceiling
    vel_tick(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      pos_tick(1'b1);
      chk("t2_pos", pos_now(), exp2[i]);
      if (i < 4) vel_tick(1'b0, 1'b1, 1'b0);
    end
    chk("t2_ceil_vel", vel_now(), 0);
    chk("t2_ceil_state", int'(bus.state), 2);
    run_to_ground();

    // Fast drop, sticky after release
    jump_to(4);
    chk("t3_start", pos_now(), -22);
    vel_tick(1'b0, 1'b0, 1'b1);
    chk("t3_drop_vel", vel_now(), 6);
    chk("t3_drop_state", int'(bus.state), 3);
    pos_tick(1'b0);
    chk("t3_pos_a", pos_now(), -16);
    vel_tick(1'b0, 1'b0, 1'b0);
    chk("t3_sticky_state", int'(bus.state), 3);
    chk("t3_sticky_vel", vel_now(), 6);
    pos_tick(1'b0);
    chk("t3_pos_b", pos_now(), -10);
    vel_tick(1'b0, 1'b0, 1'b0);
    pos_tick(1'b0);
    chk("t3_pos_c", pos_now(), -4);
    vel_tick(1'b0, 1'b0, 1'b0);
    pos_tick(1'b0);
    chk("t3_land_pos", pos_now(), 0);
    chk("t3_landed", int'(bus.landed), 1);
    cyc(2'b00, 1'b0, 1'b0, 1'b0);

    // Down on ground blocks jump; both ticks run only the velocity phase
    vel_tick(1'b1, 1'b0, 1'b1);
    chk("t4_down_vel", vel_now(), 0);
    chk("t4_down_state", int'(bus.state), 0);
    cyc(2'b11, 1'b1, 1'b0, 1'b0);
    chk("t4_both_vel", vel_now(), -7);
    chk("t4_both_pos", pos_now(), 0);
    pos_tick(1'b0);
    chk("t4_pos", pos_now(), -7);
    run_to_ground();

    // Freeze and reset during freeze
    jump_to(3);
    chk("t5_start", pos_now(), -18);
    bus.game_over = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc((i % 2 == 0) ? 2'b01 : 2'b10, 1'b1, 1'b1, logic'(i % 3 == 0));
      chk("t5_frozen_pos", pos_now(), -18);
    end
    rst = 1'b1;
    cyc(2'b00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    chk("t5_rst_pos", pos_now(), 0);
    chk("t5_rst_state", int'(bus.state), 0);
    bus.game_over = 1'b0;
    cyc(2'b00, 1'b0, 1'b0, 1'b0);

`ifdef JUMP_BUFFER_EN
    // Buffered jump consumed after landing
    jump_to(14);
    chk("t6_at", pos_now(), -7);
    vel_tick(1'b1, 1'b0, 1'b0);
    pos_tick(1'b0);
    chk("t6_pos", pos_now(), -1);
    vel_tick(1'b0, 1'b0, 1'b0);
    pos_tick(1'b0);
    chk("t6_land", int'(bus.landed), 1);
    vel_tick(1'b0, 1'b0, 1'b0);
    chk("t6_rejump_vel", vel_now(), -7);
    chk("t6_rejump_state", int'(bus.state), 1);
    // Expired buffer: no re-jump
    advance(13);
    chk("t6_at13", pos_now(), -13);
    vel_tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      pos_tick(1'b0);
      if (i < 2) vel_tick(1'b0, 1'b0, 1'b0);
    end
    chk("t6_land2", int'(bus.landed), 1);
    vel_tick(1'b0, 1'b0, 1'b0);
    chk("t6_no_rejump_state", int'(bus.state), 0);
    chk("t6_no_rejump_vel", vel_now(), 0);
`endif

    cyc(2'b00, 1'b0, 1'b0, 1'b0);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
